// File: rtl/phase_mux_seq.sv
// rtl/phase_mux_seq.sv - double-buffered carrier-phase multiplexer switching on symbol boundaries
// Optional: PHASE_MUX_IMMEDIATE_EN applies a pending select at the next sample instead of the boundary.
module phase_mux_seq #(
   parameter int NUM_PHASES = 16,
   parameter int DATA_W     = 4,
   parameter int SEL_W      = $clog2(NUM_PHASES),
   parameter int PERIOD     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_PHASES*DATA_W-1:0] phase_bus,
   input  logic                         sample_en,
   input  logic [SEL_W-1:0]             sel_in,
   input  logic                         sel_valid,
   output logic                         sel_ready,
   output logic [DATA_W-1:0]            mux_out,
   output logic                         out_valid,
   output logic                         sym_start,
   output logic                         sel_err,
   output logic                         sel_underrun
);

   localparam int               CNT_W     = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_PHASES);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state;
   logic [SEL_W-1:0] active;
   logic [SEL_W-1:0] pending;
   logic             pend_full;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             sel_bad;
   logic             sel_good;
   logic [SEL_W-1:0] use_sel;

   assign sel_ready = !rst && !pend_full;
   assign accept    = sel_valid && sel_ready;
   assign sel_bad   = accept && ({1'b0, sel_in} >= SEL_LIMIT);
   assign sel_good  = accept && !sel_bad;

`ifdef PHASE_MUX_IMMEDIATE_EN
   // A waiting select takes effect on the very sample that consumes it.
   assign use_sel = pend_full ? pending : active;
`else
   assign use_sel = active;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         active       <= '0;
         pending      <= '0;
         pend_full    <= 1'b0;
         cnt          <= '0;
         mux_out      <= '0;
         out_valid    <= 1'b0;
         sym_start    <= 1'b0;
         sel_err      <= 1'b0;
         sel_underrun <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         sym_start    <= 1'b0;
         sel_err      <= sel_bad;
         sel_underrun <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_good) begin
                  active <= sel_in;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            default: begin
               if (sample_en) begin
                  mux_out   <= phase_bus[use_sel*DATA_W +: DATA_W];
                  out_valid <= 1'b1;
                  sym_start <= (cnt == '0);
                  cnt       <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
`ifdef PHASE_MUX_IMMEDIATE_EN
                  if (pend_full) begin
                     active    <= pending;
                     pend_full <= 1'b0;
                  end
`else
                  if (cnt == CNT_LAST) begin
                     if (pend_full) begin
                        active    <= pending;
                        pend_full <= 1'b0;
                     end else begin
                        sel_underrun <= 1'b1;
                     end
                  end
`endif
               end
               // pend_full is 0 whenever an accept happens, so this never races the swap above
               if (sel_good) begin
                  pending   <= sel_in;
                  pend_full <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_mux_seq.sv
// tb/tb_phase_mux_seq.sv - scoreboard bench for phase_mux_seq (NUM_PHASES=12, PERIOD=16)
module tb_phase_mux_seq;

   localparam int NP  = 12;
   localparam int DW  = 4;
   localparam int SW  = 4;
   localparam int PER = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NP*DW-1:0] phase_bus;
   logic             sample_en;
   logic [SW-1:0]    sel_in;
   logic             sel_valid;
   logic             sel_ready;
   logic [DW-1:0]    mux_out;
   logic             out_valid;
   logic             sym_start;
   logic             sel_err;
   logic             sel_underrun;

   always #5 clk = ~clk;

   phase_mux_seq #(.NUM_PHASES(NP), .DATA_W(DW), .SEL_W(SW), .PERIOD(PER)) u_dut (
      .clk(clk), .rst(rst), .phase_bus(phase_bus), .sample_en(sample_en),
      .sel_in(sel_in), .sel_valid(sel_valid), .sel_ready(sel_ready),
      .mux_out(mux_out), .out_valid(out_valid), .sym_start(sym_start),
      .sel_err(sel_err), .sel_underrun(sel_underrun)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          s;
   } samp_t;

   samp_t q[$];

   int checks   = 0;
   int failures = 0;

   logic          m_state   = 1'b0;
   logic [SW-1:0] m_active  = '0;
   logic [SW-1:0] m_pending = '0;
   logic          m_pf      = 1'b0;
   int            m_cnt     = 0;
   logic          exp_err   = 1'b0;
   logic          exp_und   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] word(input logic [NP*DW-1:0] bus, input int k);
      return bus[k*DW +: DW];
   endfunction

   // Drive one cycle of stimulus, advance the reference model, then check what the DUT produced.
   task automatic tick(input logic sen, input logic sv, input logic [SW-1:0] si);
      logic  acc;
      logic  good;
      int    use_k;
      samp_t e;
      sample_en = sen;
      sel_valid = sv;
      sel_in    = si;
      #1;
      check_eq("sel_ready", 32'(sel_ready), 32'(!rst && !m_pf));
      acc     = sv && !rst && !m_pf;
      good    = acc && (int'(si) < NP);
      exp_err = 1'b0;
      exp_und = 1'b0;
      if (rst) begin
         m_state   = 1'b0;
         m_active  = '0;
         m_pending = '0;
         m_pf      = 1'b0;
         m_cnt     = 0;
      end else begin
         exp_err = acc && !good;
         if (!m_state) begin
            if (good) begin
               m_active = si;
               m_cnt    = 0;
               m_state  = 1'b1;
            end
         end else begin
            if (sen) begin
               use_k = int'(m_active);
`ifdef PHASE_MUX_IMMEDIATE_EN
               if (m_pf) use_k = int'(m_pending);
`endif
               e.d = word(phase_bus, use_k);
               e.s = (m_cnt == 0);
               q.push_back(e);
`ifdef PHASE_MUX_IMMEDIATE_EN
               if (m_pf) begin
                  m_active = m_pending;
                  m_pf     = 1'b0;
               end
               m_cnt = (m_cnt == PER - 1) ? 0 : m_cnt + 1;
`else
               if (m_cnt == PER - 1) begin
                  m_cnt = 0;
                  if (m_pf) begin
                     m_active = m_pending;
                     m_pf     = 1'b0;
                  end else begin
                     exp_und = 1'b1;
                  end
               end else begin
                  m_cnt++;
               end
`endif
            end
            if (good) begin
               m_pending = si;
               m_pf      = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
         e = q.pop_front();
         check_eq("mux_out", 32'(mux_out), 32'(e.d));
         check_eq("sym_start", 32'(sym_start), 32'(e.s));
      end else if (q.size() != 0) begin
         void'(q.pop_front());
      end
      check_eq("sel_err", 32'(sel_err), 32'(exp_err));
      check_eq("sel_underrun", 32'(sel_underrun), 32'(exp_und));
   endtask

   initial begin
      sample_en = 1'b0;
      sel_valid = 1'b0;
      sel_in    = '0;
      for (int k = 0; k < NP; k++) phase_bus[k*DW +: DW] = DW'(k);

      // reset state
      rst = 1'b1;
      tick(1'b0, 1'b0, 4'd0);
      tick(1'b1, 1'b1, 4'd3);
      check_eq("rst_mux_out", 32'(mux_out), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sym_start", 32'(sym_start), 32'd0);
      check_eq("rst_sel_ready", 32'(sel_ready), 32'd0);

      // reset mid-symbol with a pending select
      rst = 1'b0;
      tick(1'b0, 1'b1, 4'd3);
      repeat (7) tick(1'b1, 1'b0, 4'd0);
      tick(1'b0, 1'b1, 4'd9);
      check_eq("pend_blocks_ready", 32'(sel_ready), 32'd0);
      rst = 1'b1;
      tick(1'b1, 1'b0, 4'd0);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_mux_out", 32'(mux_out), 32'd0);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("ready_after_rst", 32'(sel_ready), 32'd1);
      tick(1'b1, 1'b0, 4'd0);

      // one full symbol on phase 3, then underrun
      tick(1'b0, 1'b1, 4'd3);
      repeat (15) tick(1'b1, 1'b0, 4'd0);
      tick(1'b1, 1'b0, 4'd0);
      check_eq("sym_last_data", 32'(mux_out), 32'd3);
      check_eq("underrun_pulse", 32'(sel_underrun), 32'd1);

      // mid-symbol select of 9 takes effect on the next symbol
      repeat (5) tick(1'b1, 1'b0, 4'd0);
      tick(1'b1, 1'b1, 4'd9);
      repeat (10) tick(1'b1, 1'b0, 4'd0);
      tick(1'b1, 1'b0, 4'd0);
      check_eq("first_new_sym", 32'(mux_out), 32'd9);
      repeat (15) tick(1'b1, 1'b0, 4'd0);

      // accept coinciding with boundary goes to pending
      repeat (15) tick(1'b1, 1'b0, 4'd0);
      tick(1'b1, 1'b1, 4'd2);
      repeat (16) tick(1'b1, 1'b0, 4'd0);
      check_eq("old_phase_kept", 32'(mux_out), 32'd9);
      repeat (16) tick(1'b1, 1'b0, 4'd0);
      check_eq("new_phase_next", 32'(mux_out), 32'd2);

      // out-of-range selects
      tick(1'b0, 1'b1, 4'd13);
      check_eq("sel_err_pulse", 32'(sel_err), 32'd1);
      tick(1'b1, 1'b1, 4'd14);
      repeat (4) tick(1'b1, 1'b0, 4'd0);
      check_eq("out_unchanged", 32'(mux_out), 32'd2);
      rst = 1'b1;
      tick(1'b0, 1'b0, 4'd0);
      rst = 1'b0;
      tick(1'b0, 1'b1, 4'd15);
      tick(1'b1, 1'b0, 4'd0);

      // select 5 at cnt 4 while on phase 2
      tick(1'b0, 1'b1, 4'd2);
      repeat (4) tick(1'b1, 1'b0, 4'd0);
      tick(1'b1, 1'b1, 4'd5);
      tick(1'b1, 1'b0, 4'd0);
`ifdef PHASE_MUX_IMMEDIATE_EN
      check_eq("cnt5_sample", 32'(mux_out), 32'd5);
`else
      check_eq("cnt5_sample", 32'(mux_out), 32'd2);
`endif
      repeat (12) tick(1'b1, 1'b0, 4'd0);

      // randomized traffic with changing phase words
      for (int i = 0; i < 600; i++) begin
         phase_bus = 48'({$urandom(), $urandom()});
         rst = ($urandom_range(0, 149) == 0);
         tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
         if (rst) begin
            rst = 1'b0;
            tick(1'b0, 1'b1, 4'($urandom_range(0, 11)));
         end
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
